fifo_reader: RTL and testbench

- Consumer-side controller for the team's shift FIFO read port (read / dataout / val / full).
- Polls the FIFO with single-cycle read pulses and captures each word returned with val.
- Presents captured words to a downstream valid/ready sink through a small internal output buffer.
- The FIFO has no empty flag, so emptiness is inferred from a missing val; after a miss the reader backs off before polling again.

---
 rtl/fifo_reader_if.sv | 33 +++
 rtl/fifo_reader.sv | 124 ++++++++++++
 tb/tb_fifo_reader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_if.sv
// Signal bundle between fifo_reader, the shift FIFO read port and the downstream sink.
// m_valid/m_ready: a word moves on a rising edge where both are high; once m_valid rises, m_valid and m_data hold until that edge.
interface fifo_reader_if #(
    parameter int DATA_W = 8
);
    logic              fifo_read;
    logic [DATA_W-1:0] fifo_dataout;
    logic              fifo_val;
    logic              fifo_full;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output fifo_read,
        input  fifo_dataout,
        input  fifo_val,
        input  fifo_full,
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  fifo_read,
        output fifo_dataout,
        output fifo_val,
        output fifo_full,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_reader.sv
// Polls a flagless shift FIFO, buffers returned words and hands them to a valid/ready sink.
// Define FIFO_READER_STATS_EN to add the saturating miss_cnt/word_cnt outputs.
module fifo_reader #(
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 2,
    parameter int BACKOFF   = 4
) (
    input  logic          clk,
    input  logic          reset,
`ifdef FIFO_READER_STATS_EN
    output logic [15:0]   miss_cnt,
    output logic [15:0]   word_cnt,
`endif
    input  logic          enable,
    output logic          busy,
    output logic [1:0]    dbg_state,
    fifo_reader_if.master bus
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BO_W  = $clog2(BACKOFF + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_POLL    = 2'd1,
        S_BACKOFF = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              read_q, read_d;
    logic              rd_pend_q;
    logic [BO_W-1:0]   bo_q, bo_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic              hit, miss, pop, credit;

    assign hit  = rd_pend_q && bus.fifo_val;
    assign miss = rd_pend_q && !bus.fifo_val;
    assign pop  = (cnt_q != '0) && bus.m_ready;

    // Buffered words plus reads still outstanding must leave room for one more;
    // a pop in this cycle is deliberately not counted as free space.
    assign credit = ({1'b0, cnt_q} + (CNT_W + 1)'(read_q) + (CNT_W + 1)'(rd_pend_q))
                    < (CNT_W + 1)'(BUF_DEPTH);

    always_comb begin
        state_d = state_q;
        bo_d    = bo_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_POLL;
            end
            S_POLL: begin
                if (!enable) begin
                    state_d = S_DRAIN;
                end else if (miss) begin
                    state_d = S_BACKOFF;
                    bo_d    = BO_W'(BACKOFF - 1);
                end
            end
            S_BACKOFF: begin
                if (!enable) state_d = S_DRAIN;
                else if (bus.fifo_full || bo_q == '0) state_d = S_POLL;
                else bo_d = bo_q - BO_W'(1);
            end
            S_DRAIN: begin
                if (!rd_pend_q && !read_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        read_d = (state_d == S_POLL) && credit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            read_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            bo_q      <= '0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            rd_pend_q <= read_q;
            bo_q      <= bo_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (hit) begin
                mem_q[wr_ptr_q] <= bus.fifo_dataout;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (hit && !pop) cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !hit) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

`ifdef FIFO_READER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_cnt <= '0;
            word_cnt <= '0;
        end else begin
            if (miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            if (hit && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

    assign bus.fifo_read = read_q;
    assign bus.m_valid   = (cnt_q != '0);
    assign bus.m_data    = mem_q[rd_ptr_q];
    assign busy          = (state_q != S_IDLE) || rd_pend_q || read_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue model of the shift FIFO plus an expected-word scoreboard.
module tb_fifo_reader;
    localparam int DATA_W    = 8;
    localparam int BUF_DEPTH = 2;
    localparam int BACKOFF   = 4;
    localparam int FIFO_CAP  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        busy;
    logic [1:0]  dbg_state;
`ifdef FIFO_READER_STATS_EN
    logic [15:0] miss_cnt;
    logic [15:0] word_cnt;
`endif

    fifo_reader_if #(.DATA_W(DATA_W)) bus ();

    fifo_reader #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .BACKOFF(BACKOFF)) dut (
        .clk       (clk),
        .reset     (rst_n),
`ifdef FIFO_READER_STATS_EN
        .miss_cnt  (miss_cnt),
        .word_cnt  (word_cnt),
`endif
        .enable    (enable),
        .busy      (busy),
        .dbg_state (dbg_state),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] fifo_q[$];
    logic rd_seen   = 1'b0;
    logic cur_hit   = 1'b0;
    logic cur_miss  = 1'b0;
    logic s_read    = 1'b0;
    int   miss_exp  = 0;
    int   hit_exp   = 0;
    int   delivered = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic update_full();
        bus.fifo_full = (fifo_q.size() >= FIFO_CAP);
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        if (fifo_q.size() < FIFO_CAP) fifo_q.push_back(w);
        update_full();
    endtask

    // Runs at the falling edge: scores the cycle's outputs against the model.
    task automatic monitor();
        int occ;
        int held;
        if (!rst_n) begin
            rd_seen = 1'b0;
            return;
        end
        s_read = bus.fifo_read;
        held   = exp_q.size();
        occ    = held - (cur_hit ? 1 : 0);
        check("m_valid", {31'd0, bus.m_valid}, {31'd0, occ != 0});
        check("credit", {31'd0, (held + int'(bus.fifo_read)) <= BUF_DEPTH}, 32'd1);
        if (bus.fifo_read || rd_seen) check("busy_inflight", {31'd0, busy}, 32'd1);
`ifdef FIFO_READER_STATS_EN
        check("miss_cnt", {16'd0, miss_cnt}, miss_exp - int'(cur_miss));
        check("word_cnt", {16'd0, word_cnt}, hit_exp - int'(cur_hit));
`endif
        if (bus.m_valid && bus.m_ready && occ > 0) begin
            check("m_data", {24'd0, bus.m_data}, {24'd0, exp_q[0]});
            void'(exp_q.pop_front());
            delivered++;
        end
        rd_seen = bus.fifo_read;
    endtask

    // Runs just after the rising edge: answers the read issued in the previous cycle.
    task automatic fifo_model();
        cur_hit  = 1'b0;
        cur_miss = 1'b0;
        if (!rst_n) begin
            bus.fifo_val = 1'b0;
            return;
        end
        if (rd_seen) begin
            if (fifo_q.size() > 0) begin
                bus.fifo_val     = 1'b1;
                bus.fifo_dataout = fifo_q.pop_front();
                exp_q.push_back(bus.fifo_dataout);
                cur_hit = 1'b1;
                hit_exp++;
            end else begin
                bus.fifo_val     = 1'b0;
                bus.fifo_dataout = DATA_W'($urandom);
                cur_miss = 1'b1;
                miss_exp++;
            end
        end else begin
            bus.fifo_val     = 1'($urandom_range(0, 1));
            bus.fifo_dataout = DATA_W'($urandom);
        end
        update_full();
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        fifo_model();
    endtask

    task automatic wait_idle(input string tag);
        logic done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            step();
            done = !busy;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_miss(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = cur_miss;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic wait_delivered(input string tag, input int target);
        for (int i = 0; i < 200 && delivered < target; i++) step();
        check(tag, delivered, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [DATA_W-1:0] first;
        logic found;

        rst_n            = 1'b0;
        enable           = 1'b0;
        bus.m_ready      = 1'b0;
        bus.fifo_val     = 1'b0;
        bus.fifo_dataout = '0;
        bus.fifo_full    = 1'b0;

        // Reset with three words preloaded
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        step();
        step();
        check("rst_fifo_read", {31'd0, bus.fifo_read}, 32'd0);
        check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("rst_m_data", {24'd0, bus.m_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n       = 1'b1;
        enable      = 1'b1;
        bus.m_ready = 1'b1;

        wait_miss("t1_miss_seen");
        step();
`ifdef FIFO_READER_STATS_EN
        check("t1_stat_miss", {16'd0, miss_cnt}, 32'd1);
        check("t1_stat_word", {16'd0, word_cnt}, 32'd3);
`endif
        for (int k = 0; k < BACKOFF; k++) begin
            step();
            check("t1_backoff_gap", {31'd0, s_read}, 32'd0);
        end
        step();
        check("t1_repoll", {31'd0, s_read}, 32'd1);
        check("t1_delivered", delivered, 32'd3);
        enable = 1'b0;
        wait_idle("t1_idle");

        // Sink stalled: only BUF_DEPTH words may be taken
        bus.m_ready = 1'b0;
        d0 = delivered;
        for (int i = 0; i < 5; i++) push_word(DATA_W'($urandom));
        first  = fifo_q[0];
        enable = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("t2_left_in_fifo", fifo_q.size(), 32'd3);
        check("t2_no_read", {31'd0, s_read}, 32'd0);
        check("t2_head", {24'd0, bus.m_data}, {24'd0, first});
        for (int i = 0; i < 4; i++) step();
        check("t2_head_stable", {24'd0, bus.m_data}, {24'd0, first});
        bus.m_ready = 1'b1;
        wait_delivered("t2_delivered", d0 + 5);
        enable = 1'b0;
        wait_idle("t2_idle");

        // FIFO fills during the second backoff cycle
        enable = 1'b1;
        wait_miss("t3_miss_seen");
        step();
        step();
        d0 = delivered;
        for (int i = 0; i < FIFO_CAP; i++) push_word(DATA_W'($urandom));
        check("t3_full", {31'd0, bus.fifo_full}, 32'd1);
        step();
        check("t3_still_waiting", {31'd0, s_read}, 32'd0);
        step();
        check("t3_wake_on_full", {31'd0, s_read}, 32'd1);
        wait_delivered("t3_delivered", d0 + FIFO_CAP);
        enable = 1'b0;
        wait_idle("t3_idle");

        // Enable drops in the cycle a read goes out
        push_word(8'hA5);
        d0     = delivered;
        enable = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = bus.fifo_read;
        end
        check("t4_read_issued", {31'd0, found}, 32'd1);
        enable = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            check("t4_no_more_reads", {31'd0, s_read}, 32'd0);
        end
        check("t4_delivered", delivered, d0 + 1);
        check("t4_busy_low", {31'd0, busy}, 32'd0);

        // Asynchronous reset with a full buffer
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(DATA_W'($urandom));
        enable = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("t5_buffer_full", {31'd0, bus.m_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("t5_async_read", {31'd0, bus.fifo_read}, 32'd0);
        check("t5_async_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        fifo_q.delete();
        rd_seen  = 1'b0;
        cur_hit  = 1'b0;
        cur_miss = 1'b0;
        miss_exp = 0;
        hit_exp  = 0;
        enable   = 1'b0;
        update_full();
        step();
        step();
        rst_n = 1'b1;
        check("t5_post_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check("t5_post_m_data", {24'd0, bus.m_data}, 32'd0);
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic with steady pointer wrap
        for (int i = 0; i < 800; i++) begin
            enable      = ($urandom_range(0, 15) != 0);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) push_word(DATA_W'($urandom));
            step();
        end
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 200 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) step();
        check("t6_all_drained", exp_q.size() + fifo_q.size(), 32'd0);
        check("t6_wraps", {31'd0, delivered >= 3 * BUF_DEPTH + 20}, 32'd1);
        enable = 1'b0;
        wait_idle("t6_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
